// File: rtl/tick_multi.sv
// ============================================================================
// Module   : tick_multi
// Purpose  : Multi-channel, runtime-programmable tick generator. Each channel
//            has its own divisor, periodic/one-shot mode, pause and stop.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tick_multi #(
    parameter int P_CHANNELS    = 4,
    parameter int P_WIDTH       = 26,
    parameter int P_DEFAULT_DIV = 50_000_000
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [P_CHANNELS*P_WIDTH-1:0] i_div,
    input  logic [P_CHANNELS-1:0]         i_load,
    input  logic [P_CHANNELS-1:0]         i_start,
    input  logic [P_CHANNELS-1:0]         i_oneshot,
    input  logic [P_CHANNELS-1:0]         i_pause,
    input  logic [P_CHANNELS-1:0]         i_stop,
    output logic [P_CHANNELS-1:0]         o_tick,
    output logic [P_CHANNELS-1:0]         o_busy
);

    localparam logic [P_WIDTH-1:0] C_ONE     = P_WIDTH'(1);
    localparam logic [P_WIDTH-1:0] C_DEFAULT = P_WIDTH'(P_DEFAULT_DIV);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    for (genvar c = 0; c < P_CHANNELS; c++) begin : g_ch
        logic [P_WIDTH-1:0] w_div;
        logic [P_WIDTH-1:0] w_reload;
        logic [P_WIDTH-1:0] shadow_q, shadow_d;
        logic [P_WIDTH-1:0] cnt_q, cnt_d;
        state_t             state_q, state_d;
        logic               oneshot_q, oneshot_d;
        logic               tick_q, tick_d;
        logic               busy_q;

        assign w_div = i_div[c*P_WIDTH +: P_WIDTH];

        // The active period lives in the counter: every reload takes N from
        // the shadow (including a same-cycle load), so a mid-run load only
        // affects periods that begin after it.
        always_comb begin
            shadow_d = shadow_q;
            if (i_load[c]) begin
                shadow_d = (w_div == '0) ? C_ONE : w_div;
            end
            w_reload = shadow_d - C_ONE;
        end

        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            oneshot_d = oneshot_q;
            tick_d    = 1'b0;
            if (i_stop[c]) begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end else if (i_start[c]) begin
                state_d   = S_RUN;
                cnt_d     = w_reload;
                oneshot_d = i_oneshot[c];
            end else begin
                case (state_q)
                    S_RUN, S_PAUSE: begin
                        // Leaving PAUSE counts in the same cycle so the tick
                        // slips by exactly the number of paused cycles.
                        if (i_pause[c]) begin
                            state_d = S_PAUSE;
                        end else begin
                            state_d = S_RUN;
                            if (cnt_q == '0) begin
                                tick_d = 1'b1;
                                if (oneshot_q) begin
                                    state_d = S_IDLE;
                                end else begin
                                    cnt_d = w_reload;
                                end
                            end else begin
                                cnt_d = cnt_q - C_ONE;
                            end
                        end
                    end
                    default: begin
                        state_d = S_IDLE;
                    end
                endcase
            end
        end

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                state_q   <= S_IDLE;
                cnt_q     <= '0;
                shadow_q  <= C_DEFAULT;
                oneshot_q <= 1'b0;
                tick_q    <= 1'b0;
                busy_q    <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                shadow_q  <= shadow_d;
                oneshot_q <= oneshot_d;
                tick_q    <= tick_d;
                busy_q    <= (state_d != S_IDLE);
            end
        end

        assign o_tick[c] = tick_q;
        assign o_busy[c] = busy_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_tick_multi.sv
// ============================================================================
// Module   : tb_tick_multi
// Purpose  : Directed self-checking bench for tick_multi (default divisor 8).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tick_multi;

    localparam int NCH = 4;
    localparam int W   = 26;

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic [NCH*W-1:0] i_div;
    logic [NCH-1:0]   i_load, i_start, i_oneshot, i_pause, i_stop;
    logic [NCH-1:0]   o_tick, o_busy;

    int n_assert = 0;
    int n_fail   = 0;

    tick_multi #(
        .P_CHANNELS    (NCH),
        .P_WIDTH       (W),
        .P_DEFAULT_DIV (8)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_div     (i_div),
        .i_load    (i_load),
        .i_start   (i_start),
        .i_oneshot (i_oneshot),
        .i_pause   (i_pause),
        .i_stop    (i_stop),
        .o_tick    (o_tick),
        .o_busy    (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge; strobes set beforehand are consumed by that edge.
    task automatic step();
        @(posedge i_clk);
        #1;
        i_load  = '0;
        i_start = '0;
        i_stop  = '0;
    endtask

    task automatic set_div(input int ch, input int val);
        i_div[ch*W +: W] = W'(val);
    endtask

    // Runs n edges; bit i of pmask drives i_pause[ch] into edge i, bit i of
    // tmask is the expected o_tick[ch] after edge i (all other channels idle).
    task automatic watch(input int ch, input int n, input logic [63:0] tmask,
                         input logic [63:0] pmask, input string tag);
        for (int i = 1; i <= n; i++) begin
            i_pause[ch] = pmask[i];
            step();
            chk($sformatf("%s[%0d]", tag, i), 32'(o_tick), 32'(tmask[i]) << ch);
        end
        i_pause[ch] = 1'b0;
    endtask

    initial begin
        i_rst = 1'b1; i_div = '0; i_load = '0; i_start = '0;
        i_oneshot = '0; i_pause = '0; i_stop = '0;
        #1;
        step(); step();
        chk("reset_tick", 32'(o_tick), 32'h0);
        chk("reset_busy", 32'(o_busy), 32'h0);
        i_rst = 1'b0;

        // ch0 periodic N=5
        set_div(0, 5); i_load[0] = 1'b1; step();
        i_start[0] = 1'b1; step();
        chk("ch0_busy", 32'(o_busy), 32'h1);
        watch(0, 16, (64'd1 << 5) | (64'd1 << 10) | (64'd1 << 15), 64'd0, "ch0_n5");
        i_stop[0] = 1'b1; step();
        chk("ch0_stop_busy", 32'(o_busy), 32'h0);

        // ch1 one-shot N=3
        set_div(1, 3); i_load[1] = 1'b1; step();
        i_start[1] = 1'b1; i_oneshot[1] = 1'b1; step();
        i_oneshot[1] = 1'b0;
        watch(1, 2, 64'd0, 64'd0, "ch1_pre");
        chk("ch1_busy_before", 32'(o_busy[1]), 32'h1);
        watch(1, 1, 64'd2, 64'd0, "ch1_tick");
        chk("ch1_busy_drop", 32'(o_busy[1]), 32'h0);
        watch(1, 20, 64'd0, 64'd0, "ch1_quiet");

        // ch0 N=4 with a 7-cycle pause and a 3-cycle pause at counter==0
        set_div(0, 4); i_load[0] = 1'b1; step();
        i_start[0] = 1'b1; step();
        watch(0, 26,
              (64'd1 << 4) | (64'd1 << 8) | (64'd1 << 19) | (64'd1 << 26),
              ((64'd1 << 18) - (64'd1 << 11)) | ((64'd1 << 26) - (64'd1 << 23)),
              "ch0_pause");
        i_stop[0] = 1'b1; step();

        // ch2 N=10, reload to 3 mid-period, then divisor 0
        set_div(2, 10); i_load[2] = 1'b1; step();
        i_start[2] = 1'b1; step();
        watch(2, 4, 64'd0, 64'd0, "ch2_n10");
        set_div(2, 3); i_load[2] = 1'b1;
        watch(2, 15, (64'd1 << 6) | (64'd1 << 9) | (64'd1 << 12) | (64'd1 << 15),
              64'd0, "ch2_n3");
        set_div(2, 0); i_load[2] = 1'b1;
        watch(2, 8, 64'h1F8, 64'd0, "ch2_n1");
        i_stop[2] = 1'b1; step();
        chk("ch2_stop_tick", 32'(o_tick), 32'h0);
        chk("ch2_stop_busy", 32'(o_busy), 32'h0);

        // ch3 stop beats start; restart at counter==0 with same-cycle load
        i_stop[3] = 1'b1; i_start[3] = 1'b1; step();
        chk("ch3_stopstart_busy", 32'(o_busy), 32'h0);
        watch(3, 10, 64'd0, 64'd0, "ch3_idle");
        set_div(3, 3); i_load[3] = 1'b1; i_start[3] = 1'b1; step();
        watch(3, 5, 64'd1 << 3, 64'd0, "ch3_n3");
        i_start[3] = 1'b1;
        watch(3, 7, (64'd1 << 4) | (64'd1 << 7), 64'd0, "ch3_restart");

        // reset mid-run, then ch0 falls back to the default divisor of 8
        set_div(2, 1); i_load[2] = 1'b1; step();
        i_start = 4'hF; step();
        step(); step();
        i_rst = 1'b1; step();
        chk("rst_mid_tick", 32'(o_tick), 32'h0);
        chk("rst_mid_busy", 32'(o_busy), 32'h0);
        i_rst = 1'b0;
        i_start[0] = 1'b1; step();
        watch(0, 17, (64'd1 << 8) | (64'd1 << 16), 64'd0, "ch0_default");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
